// File: rtl/fetch_pkg.sv
//==============================================================================
// Module : fetch_pkg
// Brief  : Shared widths, entry type and reset PC for the fetch queue.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package fetch_pkg;

   localparam int FETCH_ADDR_W = 32;
   localparam int FETCH_INST_W = 32;

   localparam logic [FETCH_ADDR_W-1:0] C_RESET_PC = '0;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_INST_W-1:0] inst;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue_ptr.sv
//==============================================================================
// Module : fetch_queue_ptr
// Brief  : Wrapping queue pointer with increment and synchronous clear.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module fetch_queue_ptr #(
   parameter int PW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clr,
   input  logic          i_inc,
   output logic [PW-1:0] o_ptr
);

   logic [PW-1:0] r_ptr;

   // Power-of-two depth lets the pointer wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= r_ptr + PW'(1);
      end
   end

   assign o_ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
//==============================================================================
// Module : fetch_queue
// Brief  : {pc, inst} fetch FIFO with flush; optional stall counter under
//          macro FETCH_Q_STATS_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module fetch_queue
   import fetch_pkg::*;
#(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter int INST_W = FETCH_INST_W,
   parameter int DEPTH  = 4,
   parameter int CW     = $clog2(DEPTH) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [INST_W-1:0] in_inst,
   output logic              in_ready,
   input  logic              flush,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_pc,
   output logic [INST_W-1:0] out_inst,
   input  logic              out_ready,
`ifdef FETCH_Q_STATS_EN
   output logic [31:0]       stall_cycles,
`endif
   output logic [CW-1:0]     count
);

   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } entry_t;

   entry_t         r_mem [DEPTH];
   logic [CW-1:0]  r_count;
   logic [PW-1:0]  w_wr_ptr;
   logic [PW-1:0]  w_rd_ptr;
   logic           w_in_ready;
   logic           w_out_valid;
   logic           w_push;
   logic           w_pop;

   // Ready/valid come from occupancy only, so no input reaches an output.
   assign w_in_ready  = (r_count != CW'(DEPTH));
   assign w_out_valid = (r_count != '0);
   assign w_push      = in_valid  & w_in_ready  & ~flush;
   assign w_pop       = out_ready & w_out_valid & ~flush;

   fetch_queue_ptr #(.PW(PW)) u_wr_ptr (
      .clk   (clock),
      .rst   (reset),
      .i_clr (flush),
      .i_inc (w_push),
      .o_ptr (w_wr_ptr)
   );

   fetch_queue_ptr #(.PW(PW)) u_rd_ptr (
      .clk   (clock),
      .rst   (reset),
      .i_clr (flush),
      .i_inc (w_pop),
      .o_ptr (w_rd_ptr)
   );

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[w_wr_ptr] <= '{pc: in_pc, inst: in_inst};
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         r_count <= '0;
      end else if (w_push && !w_pop) begin
         r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
         r_count <= r_count - CW'(1);
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign out_pc    = w_out_valid ? r_mem[w_rd_ptr].pc   : ADDR_W'(C_RESET_PC);
   assign out_inst  = w_out_valid ? r_mem[w_rd_ptr].inst : '0;
   assign count     = r_count;

`ifdef FETCH_Q_STATS_EN
   logic [31:0] r_stall_cycles;

   // Saturating count of cycles where fetch is held off by a full queue.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_stall_cycles <= '0;
      end else if (in_valid && !w_in_ready && !flush && (r_stall_cycles != 32'hFFFF_FFFF)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire
